// File: rtl/seq_debounce_if.sv
// Handshake bundle between the debounce conditioner and its neighbours:
// raw line and controls in, qualified pulse and status out.
interface seq_debounce_if #(
  parameter int GL_W = 8
);
  logic            din;
  logic            en;
  logic            clr_glitch;
  logic            seq;
  logic            level;
  logic            busy;
  logic [GL_W-1:0] glitch_cnt;

  // Driver side: stimulus source / upstream logic.
  modport master (
    output din, en, clr_glitch,
    input  seq, level, busy, glitch_cnt
  );

  // Conditioner side.
  modport slave (
    input  din, en, clr_glitch,
    output seq, level, busy, glitch_cnt
  );
endinterface

// File: rtl/seq_debounce.sv
// Input conditioner: 2-flop synchroniser, debounce FSM, one seq pulse per
// confirmed rising edge, saturating counter of rejected transitions.
module seq_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8,
  parameter int GL_W      = 8
) (
  input logic           clk,
  input logic           rst,
  seq_debounce_if.slave bus
);
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [GL_W-1:0]  GL_MAX   = '1;

  logic             s1, s2, din_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise, glitch;

  assign din_s = s2;

  // Synchroniser: only s2 is ever seen by the FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.din;
      s2 <= s1;
    end
  end

  // State and debounce counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: a check state needs DB_CYCLES stable samples to resolve.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise      = 1'b0;
    glitch    = 1'b0;
    case (state)
      LOW: begin
        if (din_s) begin
          state_nxt = RISE_CHK;
          cnt_nxt   = '0;
        end
      end
      RISE_CHK: begin
        if (!din_s) begin
          state_nxt = LOW;
          glitch    = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          rise      = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!din_s) begin
          state_nxt = FALL_CHK;
          cnt_nxt   = '0;
        end
      end
      FALL_CHK: begin
        if (din_s) begin
          state_nxt = HIGH;
          glitch    = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = LOW;
    endcase
  end

  // Pulse register: a rise confirmed while disabled is dropped, not held.
  always_ff @(posedge clk) begin
    if (!rst) bus.seq <= 1'b0;
    else      bus.seq <= rise & bus.en;
  end

  // Glitch counter: clear beats a simultaneous glitch, saturates at max.
  always_ff @(posedge clk) begin
    if (!rst)                          bus.glitch_cnt <= '0;
    else if (bus.clr_glitch)           bus.glitch_cnt <= '0;
    else if (glitch && bus.glitch_cnt != GL_MAX)
                                       bus.glitch_cnt <= bus.glitch_cnt + GL_W'(1);
  end

  // Status decoded from registered state only.
  assign bus.level = (state == HIGH) || (state == FALL_CHK);
  assign bus.busy  = (state == RISE_CHK) || (state == FALL_CHK);
endmodule

// File: tb/tb_seq_debounce.sv
// Directed bench for seq_debounce: u0 (DB_CYCLES=4, GL_W=2) and u1
// (DB_CYCLES=1, GL_W=8) share stimulus; expected seq pulse edges are queued
// when stimulus is driven and popped by a monitor when seq is seen.
module tb_seq_debounce;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   q0[$];
  int   q1[$];
  int   bcnt;

  seq_debounce_if #(.GL_W(2)) b0 ();
  seq_debounce_if #(.GL_W(8)) b1 ();

  assign b1.din        = b0.din;
  assign b1.en         = b0.en;
  assign b1.clr_glitch = b0.clr_glitch;

  seq_debounce #(.DB_CYCLES(4), .CNT_W(8), .GL_W(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
  seq_debounce #(.DB_CYCLES(1), .CNT_W(8), .GL_W(8)) u1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: every seq pulse must match the oldest expected edge.
  always @(negedge clk) begin
    int e;
    if (b0.seq === 1'b1) begin
      if (q0.size() == 0) chk("u0_unexpected_seq", cyc, 0);
      else begin e = q0.pop_front(); chk("u0_seq_edge", cyc, e); end
    end
    if (b1.seq === 1'b1) begin
      if (q1.size() == 0) chk("u1_unexpected_seq", cyc, 0);
      else begin e = q1.pop_front(); chk("u1_seq_edge", cyc, e); end
    end
  end

  initial begin
    b0.din = 1'b0; b0.en = 1'b1; b0.clr_glitch = 1'b0;

    // Reset state
    step(3);
    chk("rst_seq",    b0.seq, 0);
    chk("rst_level",  b0.level, 0);
    chk("rst_busy",   b0.busy, 0);
    chk("rst_glitch", b0.glitch_cnt, 0);
    rst = 1'b1;
    step(3);

    // Clean rise: u0 pulse at edge 7, u1 (DB=1) at edge 4
    q0.push_back(cyc + 7); q1.push_back(cyc + 4);
    b0.din = 1'b1;
    step(6);
    chk("rise_level_e6", b0.level, 0);
    step(1);
    chk("rise_level_e7", b0.level, 1);
    chk("u1_level",      b1.level, 1);
    step(20);
    chk("rise_glitch", b0.glitch_cnt, 0);
    b0.din = 1'b0;
    step(12);
    chk("fall_level", b0.level, 0);

    // Rising glitch, 2 cycles high: u0 rejects it, u1 (DB=1) accepts it
    q1.push_back(cyc + 4);
    b0.din = 1'b1;
    step(2);
    b0.din = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (b0.busy) bcnt++;
    end
    chk("glitch_busy_cycles", bcnt, 2);
    chk("glitch_level",       b0.level, 0);
    chk("glitch_cnt1",        b0.glitch_cnt, 1);
    chk("u1_glitch_cnt0",     b1.glitch_cnt, 0);

    // Bouncy fall from HIGH: low 1, high 1, then low held
    q0.push_back(cyc + 7); q1.push_back(cyc + 4);
    b0.din = 1'b1;
    step(15);
    b0.din = 1'b0; step(1);
    b0.din = 1'b1; step(1);
    b0.din = 1'b0; step(6);
    chk("bfall_level_e8", b0.level, 1);
    step(1);
    chk("bfall_level_e9", b0.level, 0);
    chk("bfall_glitch",   b0.glitch_cnt, 2);
    chk("u1_bfall_glitch", b1.glitch_cnt, 1);

    // Enable gating: rise confirmed with en=0 never pulses
    b0.en = 1'b0;
    b0.din = 1'b1;
    step(15);
    b0.en = 1'b1;
    step(5);
    chk("en_level", b0.level, 1);
    b0.din = 1'b0;
    step(12);

    // Saturation: three more 1-cycle glitches -> 5 total on u0
    for (int i = 0; i < 3; i++) begin
      b0.din = 1'b1; step(1);
      b0.din = 1'b0; step(7);
    end
    chk("sat_u0", b0.glitch_cnt, 3);
    chk("sat_u1", b1.glitch_cnt, 4);

    // Clear coincident with a 6th glitch (glitch resolves on edge 4)
    b0.din = 1'b1; step(1);
    b0.din = 1'b0; step(2);
    b0.clr_glitch = 1'b1; step(1);
    b0.clr_glitch = 1'b0;
    chk("clr_u0", b0.glitch_cnt, 0);
    chk("clr_u1", b1.glitch_cnt, 0);
    step(5);
    chk("clr_hold", b0.glitch_cnt, 0);

    // Reset during RISE_CHK; u1 already confirmed at edge 4
    q1.push_back(cyc + 4);
    b0.din = 1'b1;
    step(4);
    chk("mid_busy", b0.busy, 1);
    rst = 1'b0;
    step(1);
    chk("mid_rst_busy",  b0.busy, 0);
    chk("mid_rst_level", b0.level, 0);
    chk("mid_rst_seq",   b0.seq, 0);
    chk("u1_rst_level",  b1.level, 0);
    q0.push_back(cyc + 7); q1.push_back(cyc + 4);
    rst = 1'b1;
    step(20);
    chk("post_rst_level", b0.level, 1);

    // Every expected pulse must have appeared
    chk("u0_missing_seq", q0.size(), 0);
    chk("u1_missing_seq", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_debounce.md
Name: seq_debounce

Overview:
- Input conditioner that sits directly upstream of the seq-pulse counting FSM and drives that FSM's seq input.
- Takes a raw, asynchronous, possibly bouncing din line and synchronises it with a 2-flop synchroniser.
- Qualifies each transition with a debounce state machine, then emits exactly one single-cycle seq pulse per confirmed rising edge.
- Counts rejected transitions (glitches) for diagnostics.

Parameters:
- DB_CYCLES, 4, consecutive stable din_s samples, after entering a check state, needed to confirm a transition (legal range 1..2^CNT_W-1).
- CNT_W, 8, width of the internal debounce counter.
- GL_W, 8, width of the saturating glitch counter.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on clk rising edge only.
- din  input  1  raw asynchronous input line.
- en  input  1  output enable; when 0, seq is held at 0.
- clr_glitch  input  1  synchronous clear of glitch_cnt.
- seq  output  1  one-cycle pulse per confirmed rising edge of din.
- level  output  1  debounced level of din.
- busy  output  1  high while a transition is being qualified.
- glitch_cnt  output  GL_W  saturating count of rejected transitions.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Synchroniser flops s1 and s2 go to 0; state goes to LOW; debounce counter goes to 0.
  - seq=0, level=0, busy=0, glitch_cnt=0.
  - Reset overrides every other input, including mid-qualification.
- Synchroniser: s1<=din, s2<=s1; din_s=s2. Only din_s feeds the FSM.
- States: LOW, RISE_CHK, HIGH, FALL_CHK.
  - LOW: din_s=1 -> RISE_CHK, cnt<=0. Otherwise stay.
  - RISE_CHK:
    - din_s=0 -> LOW, glitch event.
    - din_s=1 and cnt==DB_CYCLES-1 -> HIGH, rise confirmed.
    - Otherwise cnt<=cnt+1.
  - HIGH: din_s=0 -> FALL_CHK, cnt<=0. Otherwise stay.
  - FALL_CHK:
    - din_s=1 -> HIGH, glitch event.
    - din_s=0 and cnt==DB_CYCLES-1 -> LOW.
    - Otherwise cnt<=cnt+1.
  - Falls never produce a pulse.
- seq (registered): seq<=1 on the edge that moves RISE_CHK->HIGH, if en==1 on that edge; 0 on every other edge.
  - A rise confirmed while en==0 is dropped, not deferred.
  - seq is never high on two consecutive cycles.
- level: 1 while state is HIGH or FALL_CHK, else 0; decoded from registered state.
- busy: 1 while state is RISE_CHK or FALL_CHK.
- Latency: let edge 1 be the first clk edge at which din=1 is sampled into s1, with din held high thereafter.
  - din_s=1 after edge 2; RISE_CHK entered at edge 3.
  - HIGH entered and seq=1 after edge DB_CYCLES+3; seq=0 after edge DB_CYCLES+4.
  - With DB_CYCLES=4: seq is high between edges 7 and 8.
- DB_CYCLES=1: a check state resolves on the edge after entry (one stable sample).
- glitch_cnt:
  - Increments by 1 per glitch event and saturates at 2^GL_W-1 (no wrap).
  - clr_glitch=1 forces 0 on that edge; clear wins over a simultaneous glitch event.
  - Counts regardless of en.
- Power-up/reset with din already high: the synchroniser starts at 0, so a normal rise qualification runs and produces a seq pulse (if en=1). This is intended.
- All outputs are registered or decoded from registered state; there is no combinational path from din to any output.

Test Plan:
- Clean rise, DB_CYCLES=4, en=1, din 0->1 held 20 cycles after reset -> seq=1 exactly one cycle, between edges 7 and 8; level=1 from edge 7; glitch_cnt=0.
- Rising glitch: din high 2 cycles, then low -> no seq pulse; busy high 2 cycles; level stays 0; glitch_cnt=1.
- Bouncy fall: from HIGH, din low 1 cycle, high 1, then low held -> one glitch (glitch_cnt +1); level drops DB_CYCLES+3 edges after the final fall; no seq pulse.
- Enable gating: en=0 during a clean rise, then en=1 -> no seq pulse at all; level=1.
- Saturation/clear, GL_W=2:
  - 5 glitches -> glitch_cnt=3.
  - clr_glitch coincident with a 6th glitch -> glitch_cnt=0.
- Reset mid-operation: rst=0 during RISE_CHK -> next cycle state LOW, all outputs 0.
  - With din still high after rst=1, a fresh rise is qualified: seq pulse DB_CYCLES+3 edges after release.
